// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: operands are summed CHUNK bits per clock, LSB chunk
// first, through a registered carry, with valid/ready handshakes on both sides.
module adder_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    // state | meaning
    // IDLE  | waiting for an operand handshake
    // CALC  | summing one chunk per clock
    // DONE  | result presented until consumer accepts

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("adder_seq: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   op_a, op_b, sum_r;
    logic               carry_reg, carry_r, ovf_r;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        base;
    logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_s;
    logic               chunk_c;
    logic               last;

    always_comb begin
        base    = 32'(idx) * 32'(CHUNK);
        chunk_a = op_a[base +: CHUNK];
        chunk_b = op_b[base +: CHUNK];
        {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK + 1)'(carry_reg);
        last    = (idx == IDX_W'(NCHUNK - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            sum_r     <= '0;
            carry_reg <= 1'b0;
            carry_r   <= 1'b0;
            ovf_r     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a      <= a;
                        op_b      <= sub ? ~b : b;
                        carry_reg <= sub;
                        idx       <= '0;
                    end
                end
                CALC: begin
                    sum_r[base +: CHUNK] <= chunk_s;
                    carry_reg            <= chunk_c;
                    idx                  <= idx + 1'b1;
                    if (last) begin
                        carry_r <= chunk_c;
                        // On the final chunk, the MSB of the sum is the top bit of chunk_s.
                        ovf_r   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                   (chunk_s[CHUNK-1] != op_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign carry     = carry_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq: scoreboarded operations on the 8/2 instance plus
// latency/result sweep over CHUNK=8, CHUNK=1 and a 32-bit/4 instance.
module tb_adder_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, sub;
    logic [7:0]  a, b;
    logic [31:0] a32, b32;

    logic        m_in_ready, m_out_valid, m_carry, m_ovf;
    logic [7:0]  m_sum;
    logic        c8_in_ready, c8_out_valid, c8_carry, c8_ovf;
    logic [7:0]  c8_sum;
    logic        c1_in_ready, c1_out_valid, c1_carry, c1_ovf;
    logic [7:0]  c1_sum;
    logic        w_in_ready, w_out_valid, w_carry, w_ovf;
    logic [31:0] w_sum;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    adder_seq #(.WIDTH(8), .CHUNK(2)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(m_out_valid), .out_ready(out_ready),
        .sum(m_sum), .carry(m_carry), .overflow(m_ovf));

    adder_seq #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c8_in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(c8_out_valid), .out_ready(out_ready),
        .sum(c8_sum), .carry(c8_carry), .overflow(c8_ovf));

    adder_seq #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c1_in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(c1_out_valid), .out_ready(out_ready),
        .sum(c1_sum), .carry(c1_carry), .overflow(c1_ovf));

    adder_seq #(.WIDTH(32), .CHUNK(4)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a32), .b(b32), .sub(1'b0), .out_valid(w_out_valid), .out_ready(out_ready),
        .sum(w_sum), .carry(w_carry), .overflow(w_ovf));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic s, input int hold);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] full;
        logic [9:0] cap;
        int         lat;
        int         guard;
        bb     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, bb} + 9'(s);
        e.sum   = full[7:0];
        e.carry = full[8];
        e.ovf   = (x[7] == bb[7]) && (full[7] != x[7]);

        guard = 0;
        @(negedge clk);
        while (!m_in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_op", {63'd0, m_in_ready}, 64'd1);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands while the block computes; the result must not move.
        a = ~x; b = x ^ y; sub = ~s;

        lat = 0;
        while (!m_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sum", {56'd0, m_sum}, {56'd0, e.sum});
            check("carry", {63'd0, m_carry}, {63'd0, e.carry});
            check("overflow", {63'd0, m_ovf}, {63'd0, e.ovf});
        end else begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end
        check("in_ready_in_done", {63'd0, m_in_ready}, 64'd0);

        cap = {m_sum, m_carry, m_ovf};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("backpressure_hold", {52'd0, m_out_valid, m_in_ready, m_sum, m_carry, m_ovf},
                  {52'd0, 1'b1, 1'b0, cap});
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_accept", {62'd0, m_in_ready, m_out_valid}, {62'd0, 2'b10});
    endtask

    initial begin
        int lat_m, lat_c8, lat_c1, lat_w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        a = '0; b = '0;
        a32 = 32'hFFFF_FFFF; b32 = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", {52'd0, m_in_ready, m_out_valid, m_sum, m_carry, m_ovf},
              {52'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});

        do_op(8'd200, 8'd100, 1'b0, 0);
        do_op(8'd100, 8'd100, 1'b0, 0);
        do_op(8'd128, 8'd128, 1'b0, 0);
        do_op(8'd5,   8'd7,   1'b1, 0);
        do_op(8'd7,   8'd5,   1'b1, 10);
        for (int i = 0; i < 4; i++)
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);

        // Abort an operation during its second compute cycle.
        @(negedge clk);
        a = 8'd9; b = 8'd9; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_calc", {52'd0, m_in_ready, m_out_valid, m_sum, m_carry, m_ovf},
              {52'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
        repeat (6) @(negedge clk);
        check("no_stale_result", {63'd0, m_out_valid}, 64'd0);
        do_op(8'd3, 8'd4, 1'b0, 0);

        // Parameter sweep: all instances start from reset together.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        a = 8'd200; b = 8'd100; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat_m = 99; lat_c8 = 99; lat_c1 = 99; lat_w = 99;
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) @(negedge clk);
            if (m_out_valid  && lat_m  == 99) lat_m  = n;
            if (c8_out_valid && lat_c8 == 99) lat_c8 = n;
            if (c1_out_valid && lat_c1 == 99) lat_c1 = n;
            if (w_out_valid  && lat_w  == 99) lat_w  = n;
        end
        check("sweep_lat_chunk2", 64'(lat_m), 64'd4);
        check("sweep_lat_chunk8", 64'(lat_c8), 64'd1);
        check("sweep_lat_chunk1", 64'(lat_c1), 64'd8);
        check("sweep_lat_w32", 64'(lat_w), 64'd8);
        check("sweep_chunk8_result", {54'd0, c8_sum, c8_carry, c8_ovf}, {54'd0, 8'd44, 1'b1, 1'b0});
        check("sweep_chunk1_result", {54'd0, c1_sum, c1_carry, c1_ovf}, {54'd0, 8'd44, 1'b1, 1'b0});
        check("sweep_w32_result", {30'd0, w_sum, w_carry, w_ovf}, {30'd0, 32'd0, 1'b1, 1'b0});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("sweep_all_idle", {60'd0, m_in_ready, c8_in_ready, c1_in_ready, w_in_ready},
              {60'd0, 4'b1111});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the team's combinational 1-bit and 4-bit adders. Operands are accepted over a valid/ready handshake and summed CHUNK bits per clock, LSB chunk first, through a registered carry. The result is then presented on a valid/ready output handshake. Used where wide operands must meet timing at low area; WIDTH and CHUNK trade latency against adder size.

Parameters:
WIDTH  8  operand and result width in bits; must be >= 2
CHUNK  2  bits summed per clock; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0. Violation -> elaboration $error.
(derived) NCHUNK = WIDTH/CHUNK, the number of compute cycles

Ports:
clk        input   1      rising-edge clock, single domain
rst        input   1      synchronous, active-high reset
in_valid   input   1      operand set a/b/sub is valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A, unsigned or two's complement
b          input   WIDTH  operand B
sub        input   1      0: a+b, 1: a-b
out_valid  output  1      result fields are valid
out_ready  input   1      consumer accepts the result
sum        output  WIDTH  result modulo 2^WIDTH
carry      output  1      carry out of MSB. For sub: 1 = no borrow (a >= b unsigned).
overflow   output  1      two's-complement signed overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset (rst sampled high at a clk edge) puts the block in state IDLE. After reset: in_ready=1, out_valid=0, sum=0, carry=0, overflow=0. All internal operand/carry/chunk-index registers are cleared.
- Reset has priority over all other events, including mid-CALC and in DONE. An in-flight operation is discarded and produces no output.
- FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state.
- IDLE: on in_valid && in_ready at an edge:
  - latch A = a and B' = sub ? ~b : b;
  - carry register = sub;
  - chunk index = 0;
  - go to CALC.
  - in_valid without handshake changes nothing.
- CALC: each edge computes chunk k = index as {c, s} = A[k] + B'[k] + carry_reg. s is written to sum bits [k*CHUNK +: CHUNK], c goes to carry_reg, and index increments.
  - When index == NCHUNK-1, go to DONE, with carry = final c.
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), evaluated on the final chunk.
  - in_valid is ignored during CALC.
- Latency: input handshake at edge E0 -> out_valid high after edge E0+NCHUNK. With CHUNK==WIDTH, out_valid is high after E0+1.
- DONE: sum/carry/overflow are held stable while out_valid && !out_ready (backpressure of any length). On out_valid && out_ready at an edge, go to IDLE; in_ready is high on the next cycle.
- Throughput: one operation per NCHUNK+2 cycles minimum. There is no overlap of input acceptance with DONE.
- sum/carry/overflow are not cleared on leaving DONE; they keep their last value until the next CALC overwrites them. Consumers must qualify with out_valid.
- Operands a/b/sub are sampled only on the input handshake. Changes afterwards have no effect on the result.
- Width rule: no internal truncation beyond WIDTH. The carry chain spans exactly WIDTH bits.

Test Plan:
(All with WIDTH=8, CHUNK=2 unless noted.)
- Add with carry: a=200, b=100, sub=0, handshake at E0 -> out_valid after E0+4; sum=44, carry=1, overflow=0.
- Signed overflow: a=100, b=100, sub=0 -> sum=200, carry=0, overflow=1. Then a=128, b=128 -> sum=0, carry=1, overflow=1.
- Subtract with borrow: a=5, b=7, sub=1 -> sum=254, carry=0, overflow=0. Then a=7, b=5, sub=1 -> sum=2, carry=1, overflow=0.
- Backpressure and operand isolation:
  - hold out_ready=0 for 10 cycles -> out_valid stays 1 and outputs are stable; in_ready=0 throughout.
  - a/b toggled during CALC do not alter the result.
  - out_ready=1 -> IDLE next cycle.
- Reset mid-operation: assert rst during the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, sum=0. A subsequent 3+4 gives sum=7 with no stale result.
- Parameter sweep:
  - CHUNK=8 -> latency 1.
  - CHUNK=1 -> latency 8.
  - WIDTH=32, CHUNK=4: 0xFFFFFFFF+1 -> sum=0, carry=1, overflow=0.
  - WIDTH=8, CHUNK=3 -> elaboration error.
